edn_req_arb: RTL
================

Name: edn_req_arb

Overview:
- Shares one EDN endpoint (the AST-side entropy port carrying edn_ack / edn_fips / edn_bus) between NumReq entropy consumers inside the RoT.
- Arbitrates round-robin and holds the upstream request until it is acknowledged.
- Delivers the 32-bit entropy word, with its FIPS flag, only to the granted consumer.
- Includes a watchdog that flags a stalled upstream, e.g. a tied-off fake source in simulation.

Parameters:
- NumReq, 4, number of consumer ports (2..8).
- TimeoutCycles, 1024, cycles without upstream ack before the timeout error is raised (≥2).
- CntW, 11, counter width; must hold TimeoutCycles.

Ports:
- clk_i  in  1  block clock.
- rst_ni  in  1  asynchronous active-low reset.
- cons_req_i  in  NumReq  per-consumer entropy request, level.
- cons_ack_o  out  NumReq  per-consumer one-cycle ack; data valid in that cycle.
- cons_bus_o  out  32  entropy word, shared by all consumers.
- cons_fips_o  out  1  FIPS flag for cons_bus_o.
- edn_req_o  out  1  upstream request.
- edn_ack_i  in  1  upstream ack; edn_bus_i and edn_fips_i are valid when it is high.
- edn_bus_i  in  32  upstream entropy word.
- edn_fips_i  in  1  upstream FIPS flag.
- gnt_idx_o  out  3  index of the current grant; 0 when idle.
- busy_o  out  1  high in states REQ and DLV.
- timeout_o  out  1  sticky timeout error.
- timeout_clr_i  in  1  clears timeout_o.

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr=0, counter=0.
- States and transitions:
  - IDLE: if any cons_req_i bit is set, grant the first requester found searching upward from rr_ptr (wrapping at NumReq-1 to 0). Latch gnt. Next state REQ. edn_req_o rises in the next cycle.
  - REQ: edn_req_o=1; the counter increments each cycle.
    - If edn_ack_i=1: latch edn_bus_i and edn_fips_i, clear the counter, next state DLV.
    - If the counter reaches TimeoutCycles-1 without an ack: set timeout_o, drop edn_req_o, next state IDLE; rr_ptr still advances.
  - DLV (1 cycle): cons_ack_o[gnt]=1 if cons_req_i[gnt] is still high; drive cons_bus_o and cons_fips_o from the latched values. rr_ptr = gnt+1 (mod NumReq). Next state IDLE.
- Latency: from an upstream ack at cycle t, the consumer ack occurs at t+1. The minimum consumer-request-to-ack time is 3 cycles (IDLE, REQ with immediate ack, DLV).
- Exactly one arbitration per word. A consumer holding its request receives one word per grant, then competes again. Arbitration restarts in IDLE, so the minimum period per word is 3 cycles.
- Consumer drops its request while in REQ: the upstream transaction still completes (the EDN rule forbids withdrawing a request). In DLV the word is discarded, no ack is given, and the pointer advances normally.
- Outside DLV: cons_bus_o=0 and cons_fips_o=0, so entropy never lingers on the shared bus.
- edn_ack_i while not in REQ: ignored, no state change.
- Counter is clamped at TimeoutCycles-1; no wrap.
- timeout_clr_i and a new timeout in the same cycle: set wins.
- gnt_idx_o holds the latched grant in REQ and DLV, and is 0 in IDLE.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0; the latched word is cleared.
- cons_ack_o is one-hot or zero at all times.

Test Plan:
1. Single requester, no contention: cons_req_i=4'b0100; upstream acks 2 cycles after edn_req_o with edn_bus_i=32'hDEADBEEF and fips=1.
   -> cons_ack_o=4'b0100 for exactly 1 cycle, one cycle after the ack; cons_bus_o=DEADBEEF and cons_fips_o=1 in that cycle; bus is 0 otherwise.
2. Round-robin fairness: all four requests held high; upstream acks immediately.
   -> grant order 0,1,2,3,0,1; one word every 3 cycles; no consumer is served twice before each other requester has been served.
3. Withdrawn request: consumer 1 drops its request 1 cycle into REQ; upstream acks with 32'h12345678.
   -> edn_req_o held until ack; no cons_ack_o pulse; the next grant starts searching from index 2.
4. Timeout: TimeoutCycles=16 and edn_ack_i tied 0, as with a fake tied-off source.
   -> edn_req_o high for 16 cycles, then low; timeout_o=1 and sticky; no cons_ack_o.
   -> Pulsing timeout_clr_i clears timeout_o; the next request is arbitrated normally.
5. Reset mid-REQ: rst_ni pulled low while edn_req_o=1 and gnt=3.
   -> all outputs 0 asynchronously; after release rr_ptr=0, and the first grant goes to the lowest active index.
6. Spurious ack: edn_ack_i pulsed while in IDLE with data 32'hFFFFFFFF.
   -> no cons_ack_o; cons_bus_o stays 0; busy_o stays 0.

Source files
------------

// File: rtl/edn_req_arb.sv
// edn_req_arb: round-robin sharing of one EDN entropy endpoint among NumReq consumers,
// with a sticky watchdog for a stalled upstream.
module edn_req_arb #(
  parameter int NumReq        = 4,
  parameter int TimeoutCycles = 1024,
  parameter int CntW          = 11
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] cons_req_i,
  output logic [NumReq-1:0] cons_ack_o,
  output logic [31:0]       cons_bus_o,
  output logic              cons_fips_o,
  output logic              edn_req_o,
  input  logic              edn_ack_i,
  input  logic [31:0]       edn_bus_i,
  input  logic              edn_fips_i,
  output logic [2:0]        gnt_idx_o,
  output logic              busy_o,
  output logic              timeout_o,
  input  logic              timeout_clr_i
);
  typedef enum logic [1:0] {Idle, Req, Dlv} state_e;
  localparam logic [NumReq-1:0] One = 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);
  state_e state;
  logic [2:0] rr_ptr, pick, nxt;
  logic [CntW-1:0] cnt;
  int d, best;
  // pick the requester with the smallest upward distance from rr_ptr
  always_comb begin
    pick = '0;
    best = NumReq;
    d = 0;
    for (int i = 0; i < NumReq; i++) begin
      d = (i >= int'(rr_ptr)) ? i - int'(rr_ptr) : i + NumReq - int'(rr_ptr);
      if (cons_req_i[i] && d < best) begin
        best = d;
        pick = 3'(i);
      end
    end
  end
  assign nxt = (gnt_idx_o == 3'(NumReq - 1)) ? 3'd0 : gnt_idx_o + 3'd1;
  // a consumer that withdrew while waiting gets no ack; the word is dropped
  assign cons_ack_o = (state == Dlv) ? cons_req_i & (One << gnt_idx_o) : '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= Idle;
      rr_ptr      <= '0;
      cnt         <= '0;
      gnt_idx_o   <= '0;
      edn_req_o   <= 1'b0;
      busy_o      <= 1'b0;
      timeout_o   <= 1'b0;
      cons_bus_o  <= '0;
      cons_fips_o <= 1'b0;
    end else begin
      if (timeout_clr_i) timeout_o <= 1'b0;
      case (state)
        Idle: if (|cons_req_i) begin
          state     <= Req;
          gnt_idx_o <= pick;
          edn_req_o <= 1'b1;
          busy_o    <= 1'b1;
          cnt       <= '0;
        end
        Req: if (edn_ack_i) begin
          state       <= Dlv;
          edn_req_o   <= 1'b0;
          cnt         <= '0;
          cons_bus_o  <= edn_bus_i;
          cons_fips_o <= edn_fips_i;
        end else if (cnt == CntMax) begin
          state     <= Idle;
          edn_req_o <= 1'b0;
          busy_o    <= 1'b0;
          timeout_o <= 1'b1;
          rr_ptr    <= nxt;
          gnt_idx_o <= '0;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        Dlv: begin
          state       <= Idle;
          busy_o      <= 1'b0;
          rr_ptr      <= nxt;
          gnt_idx_o   <= '0;
          cons_bus_o  <= '0;
          cons_fips_o <= 1'b0;
        end
        default: state <= Idle;
      endcase
    end
  end
endmodule
